bcd4_to_bin: RTL and testbench

- Sequential converter from 4-digit packed BCD to binary, using reverse double-dabble (shift right, then subtract 3 from each nibble that is >= 8).
- Inverse of the display path's binary-to-BCD split.
- Consumes decimal values from keypad/switch entry and hands back a binary count to datapath logic.
- Start/busy/done handshake, one conversion at a time, with digit-validity checking.

---
 rtl/bcd4_to_bin.sv | 130 +++++++++++++
 tb/tb_bcd4_to_bin.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd4_to_bin.sv
// ---------------------------------------------------------------------------
// bcd4_to_bin
//
// Sequential packed-BCD to binary converter using reverse double-dabble.
// Each SHIFT cycle shifts the {bcd, bin} register right by one and then
// subtracts 3 from every BCD nibble that reads >= 8. After N_BIN iterations
// the low N_BIN bits hold the binary value and the BCD field is empty.
//
// Ports:
//   clk      in   1        system clock, rising edge
//   rst_n    in   1        asynchronous active-low reset
//   start    in   1        conversion request, sampled only while idle
//   bcd_in   in   4*N_DIG  packed BCD, digit 0 (units) in bits [3:0]
//   busy     out  1        conversion in progress
//   done     out  1        one-cycle pulse when a result or error is posted
//   err      out  1        last request had a nibble > 9 (held until next start)
//   bin_out  out  N_BIN    last conversion result (held until next result)
//
// Handshake: a request is accepted on a rising edge where start=1 and the
// converter is idle (busy=0). bcd_in is captured only on that edge. A
// request with a bad digit is answered on the same edge (done=1, err=1,
// bin_out=0) and never raises busy. A good request raises busy on the
// accepting edge t0 and posts done=1, busy=0 and the result at t0+N_BIN.
// start while busy is dropped. start during the done cycle is accepted,
// so back-to-back conversions complete every N_BIN+1 cycles.
// ---------------------------------------------------------------------------
module bcd4_to_bin #(
    parameter int N_DIG = 4,
    parameter int N_BIN = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [4*N_DIG-1:0] bcd_in,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [N_BIN-1:0]   bin_out
);

    localparam int BCD_W  = 4 * N_DIG;
    localparam int SREG_W = BCD_W + N_BIN;
    localparam int CNT_W  = (N_BIN > 1) ? $clog2(N_BIN) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Current FSM state; a plain named signal so checkers can bind to it.
    state_t             state;
    logic [SREG_W-1:0]  sreg;
    logic [CNT_W-1:0]   count;

    logic               digit_err;
    logic [SREG_W-1:0]  shifted;
    logic [SREG_W-1:0]  corrected;
    logic [3:0]         nib;

    // Any incoming digit above 9 makes the whole request invalid.
    always_comb begin
        digit_err = 1'b0;
        for (int i = 0; i < N_DIG; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                digit_err = 1'b1;
            end
        end
    end

    // One reverse double-dabble step. A nibble >= 8 after the shift means a
    // '1' moved down from the next decimal digit (worth 10, i.e. 5 after the
    // halving, but 8 in binary), so 3 is removed. No underflow is possible.
    always_comb begin
        shifted   = sreg >> 1;
        corrected = shifted;
        nib       = 4'd0;
        for (int i = 0; i < N_DIG; i++) begin
            nib = shifted[N_BIN + 4*i +: 4];
            if (nib >= 4'd8) begin
                corrected[N_BIN + 4*i +: 4] = nib - 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sreg    <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            bin_out <= '0;
        end else begin
            // done is a single-cycle pulse unless re-armed below.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (digit_err) begin
                            done    <= 1'b1;
                            err     <= 1'b1;
                            bin_out <= '0;
                        end else begin
                            sreg  <= {bcd_in, {N_BIN{1'b0}}};
                            count <= '0;
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    sreg  <= corrected;
                    count <= count + 1'b1;
                    if (count == CNT_W'(N_BIN - 1)) begin
                        bin_out <= corrected[N_BIN-1:0];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd4_to_bin.sv
// ---------------------------------------------------------------------------
// tb_bcd4_to_bin
//
// Scoreboard bench for bcd4_to_bin. The driver presents one input cycle at a
// time; a decimal reference model decides whether each start is accepted and
// pushes {err, value} plus the cycle on which done must appear. A monitor on
// the falling edge checks busy every cycle and pops/compares on done.
// ---------------------------------------------------------------------------
module tb_bcd4_to_bin;

    localparam int N_DIG = 4;
    localparam int N_BIN = 14;
    localparam int BCD_W = 4 * N_DIG;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [BCD_W-1:0] bcd_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [N_BIN-1:0] bin_out;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bcd4_to_bin #(.N_DIG(N_DIG), .N_BIN(N_BIN)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bin_out (bin_out)
    );

    // ---------------- scoreboard state ----------------
    logic [N_BIN:0] exp_q[$];      // {err, bin_out}
    int             exp_cyc_q[$];  // edge index at which done must be seen
    int             next_accept = 0;
    int             busy_lo = 1;
    int             busy_hi = 0;
    int             n_checks = 0;
    int             n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: decimal interpretation of the digits, plain arithmetic.
    task automatic model_start(input logic [BCD_W-1:0] b, input int edge_idx);
        int  value;
        bit  bad;
        int  d;
        logic [BCD_W-1:0] v;
        if (edge_idx < next_accept) return;
        v     = b;
        value = 0;
        bad   = 1'b0;
        for (int i = N_DIG - 1; i >= 0; i--) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) bad = 1'b1;
            value = value * 10 + d;
        end
        if (bad) begin
            exp_q.push_back({1'b1, {N_BIN{1'b0}}});
            exp_cyc_q.push_back(edge_idx);
            next_accept = edge_idx + 1;
        end else begin
            exp_q.push_back({1'b0, N_BIN'(value)});
            exp_cyc_q.push_back(edge_idx + N_BIN);
            busy_lo     = edge_idx;
            busy_hi     = edge_idx + N_BIN - 1;
            next_accept = edge_idx + N_BIN + 1;
        end
    endtask

    function automatic logic [BCD_W-1:0] rand_bcd();
        logic [BCD_W-1:0] r;
        if ($urandom_range(0, 3) == 0) begin
            r = BCD_W'($urandom);
        end else begin
            for (int i = 0; i < N_DIG; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic s, input logic [BCD_W-1:0] b);
        @(negedge clk);
        start  = s;
        bcd_in = b;
        if (s) model_start(b, cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, rand_bcd());
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_bin"}, 32'(bin_out), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        next_accept = 0;
        busy_lo = 1;
        busy_hi = 0;
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic           exp_done;
        logic [N_BIN:0] e;
        if (rst_n === 1'b1) begin
            exp_done = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
            check("busy", 32'(busy), 32'((cyc >= busy_lo) && (cyc <= busy_hi)));
            if (done || exp_done) begin
                check("done", 32'(done), 32'(exp_done));
                if (exp_done) begin
                    e = exp_q.pop_front();
                    void'(exp_cyc_q.pop_front());
                    check("err", 32'(err), 32'(e[N_BIN]));
                    check("bin_out", 32'(bin_out), 32'(e[N_BIN-1:0]));
                end
            end
            // A done that never came leaves a stale entry behind.
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
                check("missed_done", 32'(0), 32'(1));
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = '0;
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Zero takes the full latency.
        drive(1'b1, 16'h0000);
        idle(16);
        drive(1'b1, 16'h1234);
        idle(16);
        drive(1'b1, 16'h9999);
        idle(16);

        // Bad digit: immediate error, then a clean conversion clears err.
        drive(1'b1, 16'h12A4);
        idle(2);
        drive(1'b1, 16'h0042);
        idle(16);

        // Start while busy is ignored; start held through done is accepted.
        drive(1'b1, 16'h0500);
        idle(4);
        drive(1'b1, 16'h0007);
        idle(4);
        for (int i = 0; i < 7; i++) drive(1'b1, 16'h0007);
        idle(16);

        // Abort by reset mid-conversion.
        drive(1'b1, 16'h8888);
        t0 = cyc;
        idle(5);
        do_reset("abort");
        check("abort_cycle", 32'(cyc - t0 >= 5 && cyc - t0 <= 7), 32'd1);
        drive(1'b1, 16'h0001);
        idle(16);

        // Input is captured only at the accepting edge.
        drive(1'b1, 16'h0250);
        idle(16);

        // Random traffic, including starts while busy and bad digits.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) == 0, rand_bcd());
        end
        drive(1'b0, '0);

        // Drain with a bounded wait.
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
